// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES ciphertext serializer.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_TAG_W   = 4;
   localparam int AES_SLOT_W  = AES_BLOCK_W + AES_TAG_W;

   localparam logic [AES_TAG_W-1:0] TAG_CTR = 4'b0000;
   localparam logic [AES_TAG_W-1:0] TAG_CBC = 4'b1111;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_e;

endpackage

// File: rtl/aes_ct_serializer.sv
// Serializes a captured AES wrapper frame into a 128-bit valid/ready stream, one block per beat.
// Optional build macro AES_SER_TAG_CHECK_EN adds the sticky malformed-tag flag.
module aes_ct_serializer
   import aes_pkg::*;
#(
   parameter int DATA_WIDTH = 512
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_done,
   input  logic [DATA_WIDTH+15:0] in_data,
   output logic                   busy,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [AES_BLOCK_W-1:0] m_data,
   output logic                   m_mode,
   output logic                   m_last,
   output logic                   overrun,
   output logic                   tag_err
);

   localparam int NUM_BLOCKS = DATA_WIDTH / AES_BLOCK_W;
   localparam int SLOT_W     = AES_SLOT_W;
   localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

   // Stream handshake: a beat moves on a rising edge where m_valid && m_ready;
   // while m_valid is high and m_ready low, m_data/m_mode/m_last hold and m_valid stays up.

   ser_state_e                state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [DATA_WIDTH+15:0]    frame_q;
   logic                      load;
   logic                      ovr_set;
   logic                      overrun_q;
   logic                      send;
   logic                      xfer;
   logic                      last;
   int                        slot_base;
   logic [AES_BLOCK_W-1:0]    slot_data;
   logic                      slot_mode;

   assign send      = (state_q == SER_SEND);
   assign last      = (idx_q == LAST_IDX);
   assign xfer      = send && m_ready;
   assign slot_base = int'(idx_q) * SLOT_W;
   assign slot_data = frame_q[slot_base +: AES_BLOCK_W];
   // Tag bit 0 doubles as the mode bit: 0000 -> CTR, 1111 -> CBC.
   assign slot_mode = frame_q[slot_base + AES_BLOCK_W];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      ovr_set = 1'b0;
      case (state_q)
         SER_IDLE: begin
            if (in_done) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = SER_SEND;
            end
         end
         SER_SEND: begin
            if (xfer && last) begin
               idx_d = '0;
               if (in_done) begin
                  load = 1'b1;
               end else begin
                  state_d = SER_IDLE;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + 1'b1;
               end
               ovr_set = in_done;
            end
         end
         default: begin
            state_d = SER_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SER_IDLE;
         idx_q     <= '0;
         frame_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (load) begin
            frame_q <= in_data;
         end
         if (ovr_set) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign busy    = send;
   assign m_valid = send;
   assign m_data  = send ? slot_data : '0;
   assign m_mode  = send & slot_mode;
   assign m_last  = send & last;
   assign overrun = overrun_q;

`ifdef AES_SER_TAG_CHECK_EN
   logic [AES_TAG_W-1:0] slot_tag;
   logic                 tag_bad;
   logic                 tag_err_q;

   assign slot_tag = frame_q[slot_base + AES_BLOCK_W +: AES_TAG_W];
   assign tag_bad  = (slot_tag != TAG_CTR) && (slot_tag != TAG_CBC);

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_err_q <= 1'b0;
      end else if (xfer && tag_bad) begin
         tag_err_q <= 1'b1;
      end
   end

   assign tag_err = tag_err_q;
`else
   assign tag_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed self-checking bench for aes_ct_serializer (default 512-bit frame, four slots).
module tb_aes_ct_serializer;

   localparam int DW = 512;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_done;
   logic [DW+15:0] in_data;
   logic           busy;
   logic           m_valid;
   logic           m_ready;
   logic [127:0]   m_data;
   logic           m_mode;
   logic           m_last;
   logic           overrun;
   logic           tag_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aes_ct_serializer #(.DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_done (in_done),
      .in_data (in_data),
      .busy    (busy),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_mode  (m_mode),
      .m_last  (m_last),
      .overrun (overrun),
      .tag_err (tag_err)
   );

   function automatic logic [DW+15:0] make_frame(input logic [3:0] t0, input logic [3:0] t1,
                                                  input logic [3:0] t2, input logic [3:0] t3,
                                                  input logic [7:0] base);
      logic [DW+15:0] f;
      f = '0;
      f[0*132 +: 132] = {t0, 120'b0, base + 8'd0};
      f[1*132 +: 132] = {t1, 120'b0, base + 8'd1};
      f[2*132 +: 132] = {t2, 120'b0, base + 8'd2};
      f[3*132 +: 132] = {t3, 120'b0, base + 8'd3};
      return f;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [7:0] exp_data, input logic exp_mode,
                           input logic exp_last);
      chk({tag, "_valid"}, 128'(m_valid), 128'(1));
      chk({tag, "_data"},  m_data, {120'b0, exp_data});
      chk({tag, "_mode"},  128'(m_mode), 128'(exp_mode));
      chk({tag, "_last"},  128'(m_last), 128'(exp_last));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      int cyc;
      logic exp_tag_err;
`ifdef AES_SER_TAG_CHECK_EN
      exp_tag_err = 1'b1;
`else
      exp_tag_err = 1'b0;
`endif
      rst = 1'b1; in_done = 1'b0; in_data = '0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state.
      chk("rst_valid",   128'(m_valid), 128'(0));
      chk("rst_busy",    128'(busy),    128'(0));
      chk("rst_data",    m_data,        128'(0));
      chk("rst_mode",    128'(m_mode),  128'(0));
      chk("rst_last",    128'(m_last),  128'(0));
      chk("rst_overrun", 128'(overrun), 128'(0));
      chk("rst_tagerr",  128'(tag_err), 128'(0));

      // CTR frame, m_ready always high: four back-to-back beats.
      in_done = 1'b1; in_data = make_frame(4'h0, 4'h0, 4'h0, 4'h0, 8'h01); m_ready = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_beat("ctr", 8'(8'h01 + i), 1'b0, i == 3);
         chk("ctr_busy", 128'(busy), 128'(1));
         @(negedge clk);
      end
      chk("ctr_end_valid", 128'(m_valid), 128'(0));
      chk("ctr_end_busy",  128'(busy),    128'(0));

      // CBC frame with m_ready pattern 1,0,0,1,0,0,...
      in_done = 1'b1; in_data = make_frame(4'hF, 4'hF, 4'hF, 4'hF, 8'h11); m_ready = 1'b0;
      @(negedge clk);
      in_done = 1'b0;
      beats = 0; cyc = 0;
      while (beats < 4 && cyc < 40) begin
         chk_beat("cbc", 8'(8'h11 + beats), 1'b1, beats == 3);
         m_ready = (cyc % 3 == 0);
         @(negedge clk);
         if (m_ready) beats++;
         cyc++;
      end
      chk("cbc_beats", 128'(beats), 128'(4));
      chk("cbc_cycles", 128'(cyc), 128'(10));
      chk("cbc_end_valid", 128'(m_valid), 128'(0));

      // Back-to-back frames: new in_done on the last handshake.
      in_done = 1'b1; in_data = make_frame(4'h0, 4'h0, 4'h0, 4'h0, 8'h21); m_ready = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_beat("b2b_a", 8'(8'h21 + i), 1'b0, 1'b0);
         @(negedge clk);
      end
      chk_beat("b2b_a3", 8'h24, 1'b0, 1'b1);
      in_done = 1'b1; in_data = make_frame(4'hF, 4'hF, 4'hF, 4'hF, 8'h31);
      @(negedge clk);
      in_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_beat("b2b_b", 8'(8'h31 + i), 1'b1, i == 3);
         @(negedge clk);
      end
      chk("b2b_overrun", 128'(overrun), 128'(0));
      chk("b2b_end_valid", 128'(m_valid), 128'(0));

      // Overrun: in_done while beat 1 is on the bus.
      in_done = 1'b1; in_data = make_frame(4'h0, 4'h0, 4'h0, 4'h0, 8'h41);
      @(negedge clk);
      in_done = 1'b0;
      chk_beat("ovr0", 8'h41, 1'b0, 1'b0);
      @(negedge clk);
      chk_beat("ovr1", 8'h42, 1'b0, 1'b0);
      in_done = 1'b1; in_data = make_frame(4'hF, 4'hF, 4'hF, 4'hF, 8'hA0);
      @(negedge clk);
      in_done = 1'b0;
      chk("ovr_flag", 128'(overrun), 128'(1));
      chk_beat("ovr2", 8'h43, 1'b0, 1'b0);
      @(negedge clk);
      chk_beat("ovr3", 8'h44, 1'b0, 1'b1);
      @(negedge clk);
      chk("ovr_end_valid", 128'(m_valid), 128'(0));
      repeat (3) @(negedge clk);
      chk("ovr_sticky", 128'(overrun), 128'(1));

      // Reset mid-frame while stalled; rst wins over a coincident in_done.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ovr_cleared", 128'(overrun), 128'(0));
      in_done = 1'b1; in_data = make_frame(4'h0, 4'h0, 4'h0, 4'h0, 8'h51); m_ready = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
      chk_beat("mid0", 8'h51, 1'b0, 1'b0);
      @(negedge clk);
      chk_beat("mid1", 8'h52, 1'b0, 1'b0);
      @(negedge clk);
      m_ready = 1'b0;
      chk_beat("mid2", 8'h53, 1'b0, 1'b0);
      rst = 1'b1; in_done = 1'b1; in_data = make_frame(4'hF, 4'hF, 4'hF, 4'hF, 8'hB0);
      @(negedge clk);
      rst = 1'b0; in_done = 1'b0;
      chk("mid_rst_valid", 128'(m_valid), 128'(0));
      chk("mid_rst_busy",  128'(busy),    128'(0));
      chk("mid_rst_data",  m_data,        128'(0));
      in_done = 1'b1; in_data = make_frame(4'h0, 4'h0, 4'h0, 4'h0, 8'h61); m_ready = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_beat("fresh", 8'(8'h61 + i), 1'b0, i == 3);
         @(negedge clk);
      end
      chk("fresh_end_busy", 128'(busy), 128'(0));

      // Malformed tag on slot 2.
      in_done = 1'b1; in_data = make_frame(4'h0, 4'h0, 4'h5, 4'h0, 8'h71);
      @(negedge clk);
      in_done = 1'b0;
      chk_beat("tag0", 8'h71, 1'b0, 1'b0);
      @(negedge clk);
      chk_beat("tag1", 8'h72, 1'b0, 1'b0);
      @(negedge clk);
      chk_beat("tag2", 8'h73, 1'b1, 1'b0);
      chk("tag_err_before", 128'(tag_err), 128'(0));
      @(negedge clk);
      chk("tag_err_after", 128'(tag_err), 128'(exp_tag_err));
      chk_beat("tag3", 8'h74, 1'b0, 1'b1);
      @(negedge clk);
      repeat (2) @(negedge clk);
      chk("tag_err_sticky", 128'(tag_err), 128'(exp_tag_err));
      chk("tag_end_valid", 128'(m_valid), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
